// File: rtl/axi_lite_ram_responder.sv
// AXI4-Lite slave backed by a word-addressed RAM for uncached traffic.
// The write and read channels are independent, each with at most one transaction in flight.
module axi_lite_ram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned           IDXW   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(4 * DEPTH);
    localparam logic [1:0]            OKAY   = 2'b00;
    localparam logic [1:0]            SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOT_ADDR,
        W_GOT_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    logic [31:0]           r_mem [DEPTH];

    wstate_t               r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;

    rstate_t               r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_cmt_addr;
    logic [31:0]           w_cmt_data;
    logic [3:0]            w_cmt_strb;
    logic [ADDR_WIDTH-1:0] w_cmt_off;
    logic                  w_cmt_ok;
    logic [IDXW-1:0]       w_cmt_idx;
    logic [ADDR_WIDTH-1:0] w_ar_off;
    logic                  w_ar_ok;
    logic [IDXW-1:0]       w_ar_idx;

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid  & r_wready;
    assign w_ar_hs = s_axi_arvalid & r_arready;

    // Commit operands: whichever half arrives on the committing edge comes straight from the bus.
    always_comb begin
        w_commit   = 1'b0;
        w_cmt_addr = r_awaddr;
        w_cmt_data = r_wdata;
        w_cmt_strb = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_commit   = w_aw_hs & w_w_hs;
                w_cmt_addr = s_axi_awaddr;
                w_cmt_data = s_axi_wdata;
                w_cmt_strb = s_axi_wstrb;
            end
            W_GOT_ADDR: begin
                w_commit   = w_w_hs;
                w_cmt_data = s_axi_wdata;
                w_cmt_strb = s_axi_wstrb;
            end
            W_GOT_DATA: begin
                w_commit   = w_aw_hs;
                w_cmt_addr = s_axi_awaddr;
            end
            default: w_commit = 1'b0;
        endcase
    end

    // Unsigned offset compare also rejects addresses below BASE, since they wrap high.
    assign w_cmt_off = w_cmt_addr - BASE;
    assign w_cmt_ok  = (w_cmt_off < SPAN);
    assign w_cmt_idx = w_cmt_off[IDXW+1:2];

    assign w_ar_off  = s_axi_araddr - BASE;
    assign w_ar_ok   = (w_ar_off < SPAN);
    assign w_ar_idx  = w_ar_off[IDXW+1:2];

    always_ff @(posedge clk) begin
        if (w_commit && w_cmt_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_cmt_strb[i]) begin
                    r_mem[w_cmt_idx][8*i +: 8] <= w_cmt_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_cmt_ok ? OKAY : SLVERR;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_GOT_ADDR;
                        r_awaddr  <= s_axi_awaddr;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_GOT_DATA;
                        r_wdata   <= s_axi_wdata;
                        r_wstrb   <= s_axi_wstrb;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_GOT_ADDR: begin
                    if (w_w_hs) begin
                        r_wstate  <= W_RESP;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_cmt_ok ? OKAY : SLVERR;
                    end
                end
                W_GOT_DATA: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_cmt_ok ? OKAY : SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Same-edge write to the sampled word is not visible: the RAM update lands after this read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_ar_ok ? r_mem[w_ar_idx] : '0;
                        r_rresp   <= w_ar_ok ? OKAY : SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_ram_responder.sv
// Directed self-checking bench for axi_lite_ram_responder (BASE=0, DEPTH=64).
// Inputs are driven and outputs sampled on the falling edge.
module tb_axi_lite_ram_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int unsigned n_chk;
    int unsigned n_bad;

    axi_lite_ram_responder #(
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (64),
        .ADDR_WIDTH(32)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_both(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        cyc();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("wr_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("wr_bresp", 32'(s_axi_bresp), 32'(exp_resp));
        s_axi_bready = 1'b1;
        cyc();
        s_axi_bready = 1'b0;
        chk("wr_bvalid_clr", 32'(s_axi_bvalid), 32'd0);
    endtask

    task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        cyc();
        s_axi_arvalid = 1'b0;
        chk("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rd_rdata", s_axi_rdata, exp_data);
        chk("rd_rresp", 32'(s_axi_rresp), 32'(exp_resp));
        s_axi_rready = 1'b1;
        cyc();
        s_axi_rready = 1'b0;
        chk("rd_rvalid_clr", 32'(s_axi_rvalid), 32'd0);
    endtask

    initial begin
        n_chk         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;

        repeat (3) cyc();
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
        chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("post_rst_wready", 32'(s_axi_wready), 32'd1);
        chk("post_rst_arready", 32'(s_axi_arready), 32'd1);

        // 1: simultaneous AW/W, then readback
        write_both(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
        chk("t1_awready_back", 32'(s_axi_awready), 32'd1);
        read_chk(32'h10, 32'hDEAD_BEEF, 2'b00);

        // 2: W leads AW by 3 cycles, single byte strobe
        s_axi_wdata  = 32'h0000_AB00;
        s_axi_wstrb  = 4'b0010;
        s_axi_wvalid = 1'b1;
        cyc();
        s_axi_wvalid = 1'b0;
        chk("t2_wready_low", 32'(s_axi_wready), 32'd0);
        chk("t2_awready_high", 32'(s_axi_awready), 32'd1);
        chk("t2_no_b", 32'(s_axi_bvalid), 32'd0);
        repeat (2) cyc();
        chk("t2_awready_wait", 32'(s_axi_awready), 32'd1);
        chk("t2_no_b_wait", 32'(s_axi_bvalid), 32'd0);
        s_axi_awaddr  = 32'h10;
        s_axi_awvalid = 1'b1;
        cyc();
        s_axi_awvalid = 1'b0;
        chk("t2_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("t2_bresp", 32'(s_axi_bresp), 32'd0);
        s_axi_bready = 1'b1;
        cyc();
        s_axi_bready = 1'b0;
        read_chk(32'h10, 32'hDEAD_ABEF, 2'b00);

        // 3: B back-pressure with a second write queued
        s_axi_awaddr  = 32'h30;
        s_axi_wdata   = 32'h1234_5678;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        cyc();
        s_axi_awaddr  = 32'h34;
        s_axi_wdata   = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            chk("t3_bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            chk("t3_bresp_hold", 32'(s_axi_bresp), 32'd0);
            chk("t3_awready_low", 32'(s_axi_awready), 32'd0);
            chk("t3_wready_low", 32'(s_axi_wready), 32'd0);
            cyc();
        end
        s_axi_bready = 1'b1;
        cyc();
        s_axi_bready = 1'b0;
        chk("t3_b_done", 32'(s_axi_bvalid), 32'd0);
        chk("t3_awready_back", 32'(s_axi_awready), 32'd1);
        cyc();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("t3_second_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        cyc();
        s_axi_bready = 1'b0;
        read_chk(32'h30, 32'h1234_5678, 2'b00);
        read_chk(32'h34, 32'hCAFE_F00D, 2'b00);

        // 4: out-of-range accesses and the last valid word
        write_both(32'h00, 32'hA5A5_A5A5, 4'hF, 2'b00);
        write_both(32'hFC, 32'h0BAD_CAFE, 4'hF, 2'b00);
        write_both(32'h100, 32'hFFFF_FFFF, 4'hF, 2'b10);
        read_chk(32'h100, 32'h0, 2'b10);
        read_chk(32'h00, 32'hA5A5_A5A5, 2'b00);
        read_chk(32'hFC, 32'h0BAD_CAFE, 2'b00);

        // 5: read and write commit to the same word on the same edge
        write_both(32'h20, 32'h0, 4'hF, 2'b00);
        s_axi_wdata  = 32'h1111_1111;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        cyc();
        s_axi_wvalid  = 1'b0;
        s_axi_awaddr  = 32'h20;
        s_axi_awvalid = 1'b1;
        s_axi_araddr  = 32'h20;
        s_axi_arvalid = 1'b1;
        cyc();
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        chk("t5_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("t5_rdata_old", s_axi_rdata, 32'h0);
        chk("t5_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        cyc();
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        read_chk(32'h20, 32'h1111_1111, 2'b00);

        // 6: reset with B and R both outstanding
        s_axi_awaddr  = 32'h40;
        s_axi_wdata   = 32'h5555_AAAA;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_araddr  = 32'h10;
        s_axi_arvalid = 1'b1;
        cyc();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        chk("t6_bvalid_pre", 32'(s_axi_bvalid), 32'd1);
        chk("t6_rvalid_pre", 32'(s_axi_rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_bvalid_async", 32'(s_axi_bvalid), 32'd0);
        chk("t6_rvalid_async", 32'(s_axi_rvalid), 32'd0);
        chk("t6_awready_async", 32'(s_axi_awready), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_awready_rel", 32'(s_axi_awready), 32'd1);

        // half-captured write (address only) dropped by reset
        s_axi_awaddr  = 32'h30;
        s_axi_wdata   = 32'hEEEE_EEEE;
        s_axi_awvalid = 1'b1;
        cyc();
        s_axi_awvalid = 1'b0;
        chk("t6_got_addr_wready", 32'(s_axi_wready), 32'd1);
        chk("t6_got_addr_awready", 32'(s_axi_awready), 32'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        read_chk(32'h30, 32'h1234_5678, 2'b00);
        read_chk(32'h10, 32'hDEAD_ABEF, 2'b00);
        read_chk(32'h34, 32'hCAFE_F00D, 2'b00);
        read_chk(32'h40, 32'h5555_AAAA, 2'b00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram_responder.md
Name: axi_lite_ram_responder

Overview:
AXI4-Lite slave/responder that terminates the LITE_* request sequences issued by the core's caches for uncached traffic. It is backed by a small word-addressed register/BRAM-style array. It serves as the simulation and FPGA target for non-cacheable accesses, such as peripherals and scratch memory. The write and read channels are independent, and each channel has at most one outstanding transaction.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
DEPTH, 64, number of 32-bit words; power of two, at least 2
ADDR_WIDTH, 32, width of AXI address buses (data width fixed at 32, strobe at 4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Reset (rst_n low, asynchronous): both FSMs go to IDLE. All ready and valid outputs are 0; bresp, rresp and rdata are 0. The memory array is not reset and retains its contents. Readies assert from the first rising edge after rst_n rises (registered outputs).
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH. Word index = (addr - BASE_ADDR) >> 2. Bits addr[1:0] are ignored (no misalignment error).
- Write FSM states and outputs:
  - W_IDLE: awready=1, wready=1.
  - W_GOT_ADDR: awready=0, wready=1; captured address held.
  - W_GOT_DATA: awready=1, wready=0; captured wdata and wstrb held.
  - W_RESP: awready=0, wready=0, bvalid=1.
- Write FSM transitions:
  - W_IDLE, AW handshake only -> W_GOT_ADDR.
  - W_IDLE, W handshake only -> W_GOT_DATA.
  - W_IDLE, both handshakes on the same edge -> W_RESP.
  - W_GOT_ADDR, W handshake -> W_RESP.
  - W_GOT_DATA, AW handshake -> W_RESP.
  - W_RESP, bready=1 -> W_IDLE. bvalid and bresp stay stable until the handshake.
- Write commit: happens on the edge that enters W_RESP. Only bytes with strobe=1 are updated. If the address is out of range, nothing is written and bresp=SLVERR; otherwise bresp=OKAY. bvalid rises the cycle after the last of AW/W is accepted.
- Read FSM:
  - R_IDLE (arready=1) -> AR handshake -> R_DATA on the next edge, with rvalid=1, rdata=mem[index], rresp=OKAY.
  - Out-of-range read in R_IDLE: rdata=0, rresp=SLVERR.
  - R_DATA: arready=0; rvalid, rdata and rresp held until rready=1, then -> R_IDLE with rvalid=0.
- Read latency: rvalid is 1 cycle after the AR handshake.
- Throughput: 1 read every 2 cycles with rready tied high; 1 write every 2 cycles with bready tied high.
- Read/write collision: an AR handshake and a write commit to the same word on the same edge return the pre-write data; the write still completes.
- Mid-operation reset: an in-flight transaction is dropped with no response. A half-captured write (W_GOT_ADDR or W_GOT_DATA) is discarded and memory is untouched.
- Valids never depend combinationally on the master's readies. Readies never depend combinationally on the master's valids.

Test Plan:
1. Reset, then write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF with AW and W in the same cycle -> bvalid one cycle later, bresp=00. Then read 0x10 -> rvalid 1 cycle after AR, rdata=0xDEADBEEF, rresp=00.
2. W (wdata=0x0000AB00, wstrb=4'b0010) presented 3 cycles before AW (0x10) -> wready drops after the W handshake, awready stays 1, B arrives after AW. Readback of 0x10 = 0xDEADABEF.
3. Hold bready=0 for 5 cycles after bvalid -> bvalid and bresp stable, awready=wready=0, and a second queued AW/W is not accepted until the B handshake.
4. Write 0x100 (DEPTH=64, BASE=0) -> bresp=10 and no memory change. Read 0x100 -> rdata=0, rresp=10. Read 0xFC -> OKAY.
5. Write 0x11111111 to 0x20 committing on the same edge as an AR to 0x20 whose old value is 0x0 -> rdata=0x0. A following read returns 0x11111111.
6. Assert rst_n while bvalid=1 and while rvalid=1 -> both drop immediately without waiting for a clock. After reset release, earlier written words still read back their values.
